// File: rtl/count_sequencer_if.sv
// Control and status bundle between a count_sequencer and whoever drives it
// (switch/button logic or a host FSM on one side, display/LED logic on the other).
interface count_sequencer_if #(
    parameter int CNT_W  = 4,
    parameter int WRAP_W = 8
);
    logic              start_i;
    logic              stop_i;
    logic              pause_i;
    logic              auto_reload_i;
    logic [CNT_W-1:0]  limit_i;
    logic [CNT_W-1:0]  count_o;
    logic              busy_o;
    logic              paused_o;
    logic              done_o;
    logic [WRAP_W-1:0] wrap_cnt_o;

    modport master (
        output start_i, stop_i, pause_i, auto_reload_i, limit_i,
        input  count_o, busy_o, paused_o, done_o, wrap_cnt_o
    );

    modport slave (
        input  start_i, stop_i, pause_i, auto_reload_i, limit_i,
        output count_o, busy_o, paused_o, done_o, wrap_cnt_o
    );
endinterface

// File: rtl/count_sequencer.sv
// Start/stop/pause sequencer for a small up-counter with one-shot or auto-reload mode.
// Define COUNT_PRESCALE_EN to advance the count only once every PRESC_DIV clocks.
module count_sequencer #(
    parameter int CNT_W     = 4,
    parameter int WRAP_W    = 8,
    parameter int PRESC_DIV = 50
) (
    input  logic               clock,
    input  logic               reset,
    count_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [CNT_W-1:0]  limit_q, limit_next;
    logic              reload_q, reload_next;
    logic [WRAP_W-1:0] wrap_cnt, wrap_next;
    logic              done, done_next;
    logic              busy, paused;
    logic              advance_en;
    logic              start_cmd;

`ifdef COUNT_PRESCALE_EN
    localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0] presc, presc_next;

    assign advance_en = (presc == PRESC_LAST);
`else
    // Without the prescaler every RUN cycle is an advance cycle.
    assign advance_en = (PRESC_DIV >= 1);
`endif

    // Stop beats start when both arrive in IDLE or DONE.
    assign start_cmd = bus.start_i && !bus.stop_i;

    // State register plus every registered output; busy/paused follow the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            limit_q  <= '0;
            reload_q <= 1'b0;
            wrap_cnt <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            paused   <= 1'b0;
`ifdef COUNT_PRESCALE_EN
            presc    <= '0;
`endif
        end else begin
            state    <= state_next;
            count    <= count_next;
            limit_q  <= limit_next;
            reload_q <= reload_next;
            wrap_cnt <= wrap_next;
            done     <= done_next;
            busy     <= (state_next == RUN) || (state_next == PAUSE);
            paused   <= (state_next == PAUSE);
`ifdef COUNT_PRESCALE_EN
            presc    <= presc_next;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_cmd) state_next = RUN;
            end
            RUN: begin
                if (bus.stop_i)
                    state_next = IDLE;
                else if (bus.pause_i)
                    state_next = PAUSE;
                else if (advance_en && (count == limit_q) && !reload_q)
                    state_next = DONE;
            end
            PAUSE: begin
                if (bus.stop_i)
                    state_next = IDLE;
                else if (!bus.pause_i)
                    state_next = RUN;
            end
            DONE: begin
                if (bus.stop_i)
                    state_next = IDLE;
                else if (bus.start_i)
                    state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values: count, latched settings, reload counter, done pulse.
    always_comb begin
        count_next  = count;
        limit_next  = limit_q;
        reload_next = reload_q;
        wrap_next   = wrap_cnt;
        done_next   = 1'b0;
`ifdef COUNT_PRESCALE_EN
        presc_next  = presc;
`endif
        case (state)
            IDLE, DONE: begin
                if (bus.stop_i || state == IDLE)
                    count_next = '0;
                if (start_cmd) begin
                    count_next  = '0;
                    limit_next  = bus.limit_i;
                    reload_next = bus.auto_reload_i;
                    wrap_next   = '0;
`ifdef COUNT_PRESCALE_EN
                    presc_next  = '0;
`endif
                end
            end
            RUN: begin
                if (bus.stop_i) begin
                    count_next = '0;
                end else if (!bus.pause_i) begin
`ifdef COUNT_PRESCALE_EN
                    presc_next = advance_en ? '0 : presc + PRESC_W'(1);
`endif
                    if (advance_en) begin
                        if (count != limit_q) begin
                            count_next = count + CNT_W'(1);
                        end else begin
                            done_next = 1'b1;
                            if (reload_q) begin
                                count_next = '0;
                                if (wrap_cnt != {WRAP_W{1'b1}})
                                    wrap_next = wrap_cnt + WRAP_W'(1);
                            end
                        end
                    end
                end
            end
            PAUSE: begin
                if (bus.stop_i) count_next = '0;
            end
            default: count_next = '0;
        endcase
    end

    assign bus.count_o    = count;
    assign bus.busy_o     = busy;
    assign bus.paused_o   = paused;
    assign bus.done_o     = done;
    assign bus.wrap_cnt_o = wrap_cnt;
endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer in its default build (no prescaler):
// one-shot, auto-reload, pause, stop priority, limit 0, saturation and mid-run reset.
module tb_count_sequencer;
    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    count_sequencer_if #(.CNT_W(4), .WRAP_W(8)) bus ();

    count_sequencer #(.CNT_W(4), .WRAP_W(8), .PRESC_DIV(50)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic start, input logic stop, input logic pause,
                                 input logic reload, input logic [3:0] limit);
        bus.start_i       = start;
        bus.stop_i        = stop;
        bus.pause_i       = pause;
        bus.auto_reload_i = reload;
        bus.limit_i       = limit;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] count, input logic busy,
                               input logic paused, input logic done, input logic [7:0] wrap);
        checks++;
        assert (bus.count_o === count) else begin
            errors++;
            $error("[TB] FAIL %s count_o observed=%0d expected=%0d", tag, bus.count_o, count);
        end
        checks++;
        assert (bus.busy_o === busy) else begin
            errors++;
            $error("[TB] FAIL %s busy_o observed=%b expected=%b", tag, bus.busy_o, busy);
        end
        checks++;
        assert (bus.paused_o === paused) else begin
            errors++;
            $error("[TB] FAIL %s paused_o observed=%b expected=%b", tag, bus.paused_o, paused);
        end
        checks++;
        assert (bus.done_o === done) else begin
            errors++;
            $error("[TB] FAIL %s done_o observed=%b expected=%b", tag, bus.done_o, done);
        end
        checks++;
        assert (bus.wrap_cnt_o === wrap) else begin
            errors++;
            $error("[TB] FAIL %s wrap_cnt_o observed=%0d expected=%0d", tag, bus.wrap_cnt_o, wrap);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(2);
        checkOutput("reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("idle", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // One-shot, limit 3: count 0,1,2,3 then done one clock later.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        tick(1);
        checkOutput("os3_start", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            checkOutput("os3_count", 4'(k), 1'b1, 1'b0, 1'b0, 8'd0);
        end
        tick(1);
        checkOutput("os3_done", 4'd3, 1'b0, 1'b0, 1'b1, 8'd0);
        tick(2);
        checkOutput("os3_hold", 4'd3, 1'b0, 1'b0, 1'b0, 8'd0);

        // Restart from DONE in auto-reload, limit 2.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        tick(1);
        checkOutput("rl2_start", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            checkOutput("rl2_cycle", 4'(k % 3), 1'b1, 1'b0, (k % 3) == 0, 8'(k / 3));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick(1);
        checkOutput("rl2_stop", 4'd0, 1'b0, 1'b0, 1'b0, 8'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // One-shot, limit 15, paused for 5 clocks at count 6.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
        tick(1);
        checkOutput("p15_start", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(6);
        checkOutput("p15_at6", 4'd6, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            checkOutput("p15_paused", 4'd6, 1'b1, 1'b1, 1'b0, 8'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1);
        checkOutput("p15_resume", 4'd6, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 7; k <= 15; k++) begin
            tick(1);
            checkOutput("p15_count", 4'(k), 1'b1, 1'b0, 1'b0, 8'd0);
        end
        tick(1);
        checkOutput("p15_done", 4'd15, 1'b0, 1'b0, 1'b1, 8'd0);

        // start_i held through RUN is ignored; stop with pause wins at count 9.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
        tick(1);
        checkOutput("ign_start", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            checkOutput("ign_count", 4'(k), 1'b1, 1'b0, 1'b0, 8'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd15);
        tick(1);
        checkOutput("stop_pause", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        checkOutput("stop_start_idle", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Stop while paused.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        tick(1);
        checkOutput("pause_at2", 4'd2, 1'b1, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick(1);
        checkOutput("pause_stop", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // One-shot with limit 0: done after the first edge.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1);
        checkOutput("os0_start", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1);
        checkOutput("os0_done", 4'd0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Reload with limit 0: done every clock, reload count saturates at 255.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tick(1);
        checkOutput("rl0_start", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        for (int k = 1; k <= 300; k++) begin
            tick(1);
            checkOutput("rl0_cycle", 4'd0, 1'b1, 1'b0, 1'b1, (k > 255) ? 8'd255 : 8'(k));
        end
        reset = 1'b1;
        tick(1);
        checkOutput("midrun_reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("post_reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
